// File: rtl/seq_mag_comp.sv
// ============================================================================
//  Module      : seq_mag_comp
//  Description : Multi-cycle magnitude comparator, CHUNK bits per cycle,
//                MS chunk first, unsigned or two's-complement, early exit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mag_comp #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   a,
    input  logic [WIDTH-1:0]                   b,
    input  logic                               signed_mode,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               lt,
    output logic                               eq,
    output logic                               gt,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0]   chunks
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(NCH + 1);
    localparam logic [CW-1:0] c_last_cnt = CW'(NCH - 1);
    localparam bit c_early = (EARLY_EXIT != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [CW-1:0]     r_cnt;
    logic              r_found;
    logic              r_lt_pend;
    logic              r_lt;
    logic              r_eq;
    logic              r_gt;
    logic [CW-1:0]     r_chunks;

    logic [CHUNK-1:0]  w_top_a;
    logic [CHUNK-1:0]  w_top_b;
    logic              w_diff;
    logic              w_lt;
    logic              w_last;
    logic              w_found_now;
    logic              w_done_entry;
    logic              w_res_diff;
    logic              w_res_lt;
    logic [WIDTH-1:0]  w_msb_flip;

    // Operands are shifted left each cycle, so the chunk under test is
    // always the top one and the compare depth does not grow with WIDTH.
    assign w_top_a    = r_a[WIDTH-1 -: CHUNK];
    assign w_top_b    = r_b[WIDTH-1 -: CHUNK];
    assign w_diff     = (w_top_a != w_top_b);
    assign w_lt       = (w_top_a < w_top_b);
    assign w_last     = (r_cnt == c_last_cnt);
    assign w_msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};

    assign w_res_diff = r_found | w_diff;
    assign w_res_lt   = r_found ? r_lt_pend : w_lt;

    always_comb begin
        w_state_next = r_state;
        w_found_now  = 1'b0;
        w_done_entry = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_state_next = S_SCAN;
            end
            S_SCAN: begin
                w_found_now  = !r_found && w_diff;
                w_done_entry = w_last || (c_early && w_found_now);
                if (w_done_entry) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_found   <= 1'b0;
            r_lt_pend <= 1'b0;
            r_lt      <= 1'b0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_chunks  <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Offset-binary: flipping both MSBs turns a signed
                        // compare into an unsigned one.
                        r_a     <= a ^ w_msb_flip;
                        r_b     <= b ^ w_msb_flip;
                        r_cnt   <= '0;
                        r_found <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_a   <= r_a << CHUNK;
                    r_b   <= r_b << CHUNK;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_found_now) begin
                        r_found   <= 1'b1;
                        r_lt_pend <= w_lt;
                    end
                    if (w_done_entry) begin
                        r_lt     <= w_res_diff & w_res_lt;
                        r_gt     <= w_res_diff & !w_res_lt;
                        r_eq     <= !w_res_diff;
                        r_chunks <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign lt        = r_lt;
    assign eq        = r_eq;
    assign gt        = r_gt;
    assign chunks    = r_chunks;

endmodule

`default_nettype wire

// File: tb/tb_seq_mag_comp.sv
// ============================================================================
//  Module      : tb_seq_mag_comp
//  Description : Self-checking bench for seq_mag_comp (WIDTH=16, CHUNK=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mag_comp;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b;
    logic        signed_mode;
    logic        lt, eq, gt;
    logic [2:0]  chunks;

    logic        in_valid_ne, in_ready_ne, out_valid_ne, out_ready_ne;
    logic        lt_ne, eq_ne, gt_ne;
    logic [2:0]  chunks_ne;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_mag_comp #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .lt(lt), .eq(eq), .gt(gt), .chunks(chunks)
    );

    seq_mag_comp #(.WIDTH(16), .CHUNK(4), .EARLY_EXIT(0)) dut_ne (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_ne), .in_ready(in_ready_ne),
        .a(a), .b(b), .signed_mode(signed_mode),
        .out_valid(out_valid_ne), .out_ready(out_ready_ne),
        .lt(lt_ne), .eq(eq_ne), .gt(gt_ne), .chunks(chunks_ne)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: plain integer compare plus a count of leading equal nibbles.
    function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                  input bit ee, output logic elt, output logic eeq,
                                  output logic egt, output int k);
        int leq = 0;
        bit stop = 0;
        elt = s ? ($signed(x) < $signed(y)) : (x < y);
        eeq = (x == y);
        egt = !elt && !eeq;
        for (int i = 3; i >= 0; i--) begin
            if (!stop && x[i*4 +: 4] == y[i*4 +: 4]) leq++;
            else stop = 1;
        end
        k = ee ? ((leq + 1 > 4) ? 4 : leq + 1) : 4;
    endfunction

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic s);
        int g = 0;
        @(negedge clk);
        a = ta; b = tb; signed_mode = s; in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("accept_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("result_timeout", out_valid, 1'b1);
    endtask

    task automatic check_res(input logic [15:0] ta, input logic [15:0] tb, input logic s, input int lat);
        logic elt, eeq, egt;
        int   k;
        model(ta, tb, s, 1'b1, elt, eeq, egt, k);
        check("lt", lt, elt);
        check("eq", eq, eeq);
        check("gt", gt, egt);
        check("chunks", chunks, k);
        check("latency", lat, k);
        check("onehot", $countones({lt, eq, gt}), 1);
    endtask

    task automatic run(input logic [15:0] ta, input logic [15:0] tb, input logic s);
        int lat;
        send(ta, tb, s);
        wait_res(lat);
        check_res(ta, tb, s, lat);
    endtask

    initial begin
        int          lat;
        int          prev_cyc;
        int          k;
        logic        elt, eeq, egt;
        logic [15:0] ra, rb;
        logic        rs;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_valid_ne = 1'b0; out_ready_ne = 1'b1;
        a = '0; b = '0; signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_lt_eq_gt", {lt, eq, gt}, 3'b000);
        check("rst_chunks", chunks, 3'd0);

        // Directed cases
        run(16'h1234, 16'h1234, 1'b0);
        run(16'h8000, 16'h7FFF, 1'b0);
        run(16'h8000, 16'h7FFF, 1'b1);
        run(16'h0012, 16'h0013, 1'b0);
        run(16'hFFFE, 16'hFFFF, 1'b1);

        // Constant-latency instance
        @(negedge clk);
        a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b0; in_valid_ne = 1'b1;
        check("ne_ready", in_ready_ne, 1'b1);
        @(posedge clk);
        #1 in_valid_ne = 1'b0;
        lat = 0;
        while (!out_valid_ne && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ne_gt", {lt_ne, eq_ne, gt_ne}, 3'b001);
        check("ne_chunks", chunks_ne, 3'd4);
        check("ne_latency", lat, 4);

        // Backpressure
        out_ready = 1'b0;
        send(16'h00A0, 16'h0050, 1'b0);
        wait_res(lat);
        check_res(16'h00A0, 16'h0050, 1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 16'h0001; b = 16'h0002; in_valid = 1'b1;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_result", {lt, eq, gt, chunks}, {3'b001, 3'd3});
            check("bp_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", in_ready, 1'b1);
        check("bp_release_out_valid", out_valid, 1'b0);
        repeat (6) @(posedge clk);
        #1 check("bp_ignored_no_result", out_valid, 1'b0);

        // Reset during the second SCAN cycle
        send(16'h1111, 16'h1111, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rstmid_out_valid", out_valid, 1'b0);
        check("rstmid_in_ready", in_ready, 1'b1);
        check("rstmid_lt_eq_gt", {lt, eq, gt}, 3'b000);
        check("rstmid_chunks", chunks, 3'd0);
        run(16'h0001, 16'h0000, 1'b0);

        // Back-to-back random traffic
        prev_cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = ra ^ 16'(($urandom & 32'hFFFF) >> $urandom_range(0, 16));
            rs = 1'($urandom);
            send(ra, rb, rs);
            wait_res(lat);
            check_res(ra, rb, rs, lat);
            model(ra, rb, rs, 1'b1, elt, eeq, egt, k);
            if (i > 0) check("spacing", cyc - prev_cyc, k + 2);
            prev_cyc = cyc;
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_mag_comp.md
# seq_mag_comp

Multi-cycle, parametrised magnitude comparator. It is the sequential successor to the team's fixed 16-bit combinational less/equal/greater comparator. The block accepts two WIDTH-bit operands over a valid/ready handshake and scans them CHUNK bits per cycle, most-significant chunk first. It returns a one-hot less/equal/greater result plus the number of chunks examined. It is used where a wide compare must not sit in a single combinational path. Unsigned and two's-complement modes are supported, and it can stop early at the first differing chunk.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 2.
- CHUNK, 4, bits compared per cycle; WIDTH % CHUNK must be 0; NCH = WIDTH/CHUNK.
- EARLY_EXIT, 1, 1 = finish at the first differing chunk; 0 = always scan all NCH chunks (constant latency).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  left operand.
- b  in  WIDTH  right operand.
- signed_mode  in  1  1 = two's-complement compare; sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- lt, eq, gt  out  1 each  one-hot result: a<b, a==b, a>b.
- chunks  out  $clog2(NCH+1)  number of chunks examined (1..NCH).

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE: in_ready=1. When in_valid&in_ready, register a, b, signed_mode; set idx=NCH-1, cnt=0, found=0; go to SCAN.
  - SCAN: each cycle compares chunk idx of a and b, then cnt++.
    - Signed mode: the operand MSB, which is in chunk NCH-1, is inverted in both operands before comparing (offset-binary trick).
    - First differing chunk (found=0): set found, lt/gt from the chunk's unsigned compare.
      - EARLY_EXIT=1: go to DONE.
      - EARLY_EXIT=0: keep scanning; later chunks never change the result.
    - idx==0 and found=0 at end of cycle: eq=1, go to DONE. Otherwise idx--.
  - DONE: out_valid=1; lt/eq/gt/chunks stable. On out_valid&out_ready, go to IDLE.
- in_ready=0 in SCAN and DONE. An in_valid that arrives there is ignored, not queued.
- lt/eq/gt/chunks are registered. They update only on entry to DONE and hold their value afterwards until the next DONE or reset. They are meaningful only while out_valid=1.
- Exactly one of lt/eq/gt is 1 whenever out_valid=1.
- Reset values: state=IDLE, in_ready=1 (from the first cycle after reset), out_valid=0, lt=eq=gt=0, chunks=0.
- Reset mid-SCAN or mid-DONE aborts the operation. No result is emitted and the state returns to IDLE.

## Timing
- Let edge E be the edge on which in_valid&in_ready is sampled. out_valid rises after edge E+k, where k = chunks examined.
  - EARLY_EXIT=1: k = 1 + number of leading equal chunks, capped at NCH.
  - EARLY_EXIT=0: k = NCH.
- chunks=k on out_valid.
- With out_ready=1, DONE lasts 1 cycle; in_ready is 1 on the following cycle. Maximum throughput is one compare per k+2 cycles.
- Backpressure: DONE holds indefinitely while out_ready=0, with no change on any output.
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Critical path is one CHUNK-bit compare plus the FSM update, independent of WIDTH.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 (NCH=4) unless stated.
- Equality: a=0x1234, b=0x1234, unsigned → eq=1, lt=gt=0, chunks=4, out_valid 4 edges after accept.
- MSB difference, both modes: a=0x8000, b=0x7FFF.
  - unsigned → gt=1, chunks=1.
  - signed → lt=1, chunks=1.
  - Rebuild with EARLY_EXIT=0, unsigned → gt=1, chunks=4, 4-edge latency.
- LSB difference: a=0x0012, b=0x0013 → lt=1, chunks=4.
  - Signed a=0xFFFE (-2), b=0xFFFF (-1) → lt=1, chunks=4.
- Backpressure: a=0x00A0, b=0x0050, out_ready=0 for 5 cycles → out_valid=1, gt=1, chunks=3, all stable across the 5 cycles.
  - in_ready=0 throughout; a second in_valid during this window is ignored.
  - Release out_ready → in_ready=1 next cycle.
- Reset mid-op: accept a=0x1111, b=0x1111, assert rst during the 2nd SCAN cycle.
  - Next cycle: out_valid=0, in_ready=1, lt=eq=gt=0, chunks=0.
  - A new compare a=0x0001, b=0x0000 then gives gt=1, chunks=4.
- Back-to-back random: 1000 random pairs, random signed_mode, in_valid and out_ready held at 1.
  - Results match a reference model.
  - Inter-result spacing equals k+2 cycles.
  - One-hot holds on every out_valid.
